// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by instruction fetch and the MEM stage.
// Assembles/splits 1/2/4-byte little-endian transfers; IF reads abort on a PC jump.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_from_ram_enable_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_jump_enable_i,
    output logic              inst_ready_o,
    output logic [WORD_W-1:0] inst_o,
    output logic              is_if_output_o,
    input  logic              mem_enable_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [2:0]        mem_len_i,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic              mem_ready_o,
    output logic [WORD_W-1:0] mem_data_o,
    input  logic [7:0]        ram_data_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_data_o,
    output logic              ram_wr_o
);

    typedef enum logic [1:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] mdata_q, mdata_d;
    logic              inst_rdy_q, inst_rdy_d;
    logic              mem_rdy_q, mem_rdy_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [4:0]        rd_shamt;
    logic [4:0]        wr_shamt;
    logic [WORD_W-1:0] byte_word;
    logic [7:0]        wr_byte;

    assign cur_addr  = addr_q + ADDR_W'(cnt_q);
    // The byte arriving now belongs to the address issued last cycle, i.e. lane cnt-1.
    assign rd_shamt  = {cnt_q[1:0] - 2'd1, 3'b000};
    assign wr_shamt  = {cnt_q[1:0], 3'b000};
    assign byte_word = WORD_W'(ram_data_i) << rd_shamt;
    assign wr_byte   = 8'(mem_data_i >> wr_shamt);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        inst_d     = inst_q;
        mdata_d    = mdata_q;
        inst_rdy_d = 1'b0;
        mem_rdy_d  = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wr_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    addr_d = mem_addr_i;
                    len_d  = mem_len_i;
                    if (mem_wr_i) begin
                        cnt_d   = '0;
                        state_d = MEM_WRITE;
                    end else begin
                        ram_addr_o = mem_addr_i;
                        cnt_d      = 3'd1;
                        buf_d      = '0;
                        state_d    = MEM_READ;
                    end
                end else if (if_from_ram_enable_i) begin
                    ram_addr_o = pc_i;
                    addr_d     = pc_i;
                    len_d      = 3'd4;
                    cnt_d      = 3'd1;
                    buf_d      = '0;
                    state_d    = IF_READ;
                end
            end

            IF_READ, MEM_READ: begin
                if (cnt_q < len_q) begin
                    ram_addr_o = cur_addr;
                end
                if (state_q == IF_READ && pc_jump_enable_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    buf_d = buf_q | byte_word;
                    if (cnt_q < len_q) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (state_q == IF_READ) begin
                            inst_d     = buf_d;
                            inst_rdy_d = 1'b1;
                        end else begin
                            mdata_d   = buf_d;
                            mem_rdy_d = 1'b1;
                        end
                    end
                end
            end

            MEM_WRITE: begin
                ram_wr_o   = 1'b1;
                ram_addr_o = cur_addr;
                ram_data_o = wr_byte;
                if (cnt_q == len_q - 3'd1) begin
                    cnt_d     = '0;
                    mem_rdy_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            inst_q     <= '0;
            mdata_q    <= '0;
            inst_rdy_q <= 1'b0;
            mem_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            inst_q     <= inst_d;
            mdata_q    <= mdata_d;
            inst_rdy_q <= inst_rdy_d;
            mem_rdy_q  <= mem_rdy_d;
        end
    end

    assign inst_o         = inst_q;
    assign mem_data_o     = mdata_q;
    assign inst_ready_o   = inst_rdy_q;
    assign mem_ready_o    = mem_rdy_q;
    assign is_if_output_o = (state_q == IF_READ);

endmodule
